sample_buffer: RTL
==================

Name: sample_buffer

Overview:
- Parametrised ready/valid sample FIFO; successor to the single-bit combinational buffer stage.
- Stores WIDTH-bit samples in a DEPTH-entry circular buffer. Decouples the sample producer from the consumer in the halfband interpolator datapath.
- First-word-fall-through output: the head sample is presented with Z_valid as soon as it is written.

Parameters:
- WIDTH, 16, sample width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- ADDR_W, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- A_data  in  WIDTH  input sample.
- A_valid  in  1  input sample valid.
- A_ready  out  1  buffer can accept a sample this cycle.
- Z_data  out  WIDTH  head sample.
- Z_valid  out  1  head sample valid.
- Z_ready  in  1  consumer accepts the head sample this cycle.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage and pointers:
  - Storage is DEPTH x WIDTH registers.
  - Write pointer wp and read pointer rp are ADDR_W+1 bits wide; the extra MSB is the wrap bit.
  - empty = (wp == rp). full = (index bits equal) and (MSBs differ).
  - count = wp - rp, modulo 2^(ADDR_W+1).
- Reset (asynchronous, immediate, including mid-transfer):
  - wp, rp := 0; count = 0; Z_valid = 0; Z_data = 0; A_ready = 0.
  - Storage contents are not reset.
  - The first cycle after reset deasserts has A_ready = 1 and Z_valid = 0.
- Handshake signals:
  - A_ready = !full && !reset.
  - Z_valid = !empty.
  - Z_data = mem[rp index] when Z_valid = 1, else forced to 0.
- Transfer conditions:
  - push = A_valid && A_ready. On the edge: mem[wp] := A_data; wp := wp + 1.
  - pop = Z_valid && Z_ready. On the edge: rp := rp + 1.
- Latency:
  - A sample pushed at edge n appears on Z_data with Z_valid = 1 in the cycle after edge n.
  - Minimum latency is 1 cycle; there is no combinational A->Z path.
- Throughput: one push and one pop per cycle simultaneously, sustained indefinitely at any occupancy from 1 to DEPTH-1.
- Boundary cases:
  - Full: A_ready = 0 even if Z_ready = 1 in the same cycle; no write-through when full.
    - A pop while full frees one slot; A_ready rises in the next cycle.
  - Empty: Z_ready is ignored and rp does not move.
    - A push while empty makes Z_valid = 1 in the next cycle.
  - Simultaneous push and pop at 0 < count < DEPTH: count is unchanged and data order is preserved.
  - Wrap-around: index bits wrap from DEPTH-1 to 0 and the MSB toggles. FIFO order is kept across any number of wraps.
  - Z_data and Z_valid hold stable while Z_valid = 1 and Z_ready = 0.

Optional Feature:
- Macro: SAMPLE_BUFFER_ERR_EN.
- When defined, three extra ports are added:
  - err_ovf  out  1.
  - err_udf  out  1.
  - err_clr  in  1.
- Flag behaviour with the macro:
  - err_ovf sets sticky when A_valid = 1 while full, i.e. a producer ignored backpressure. The offered sample is dropped and the FIFO is unchanged.
  - err_udf sets sticky when Z_ready = 1 while empty.
  - err_clr = 1 clears both flags on the next edge. If set and clear occur in the same cycle, set wins.
  - Both flags reset to 0.
- When undefined: the ports do not exist. Behaviour is identical apart from the missing flags; the dropped-on-full semantics are the same, since A_ready = 0.

Test Plan:
- Reset/idle: reset = 1 mid-stream with count = 3 -> immediately count = 0, Z_valid = 0, Z_data = 0. One cycle after release, A_ready = 1.
- Fill/drain (WIDTH = 8, DEPTH = 4):
  - Push 0x11, 0x22, 0x33, 0x44 with Z_ready = 0 -> count = 4, A_ready = 0, Z_data = 0x11.
  - Then Z_ready = 1 for 4 cycles -> outputs 0x11, 0x22, 0x33, 0x44 in order, then Z_valid = 0.
- Streaming: 20 consecutive pushes (0x00..0x13) with Z_ready = 1 throughout -> each value appears 1 cycle after its push. Count stays at 1 after the first push and wraps pointers 5 times with no loss.
- Full with pop: count = 4, A_valid = 1, Z_ready = 1 -> no push that cycle, head popped, count = 3. The next cycle the push is accepted and count = 4.
- Backpressure hold: Z_ready = 0 for 5 cycles with Z_valid = 1 -> Z_data is constant. Then random A_valid/Z_ready over 1000 cycles against a reference queue -> zero mismatches.
- SAMPLE_BUFFER_ERR_EN:
  - A_valid = 1 while full -> err_ovf = 1 next cycle and count stays 4.
  - Z_ready = 1 while empty -> err_udf = 1.
  - err_clr pulse -> both flags 0 on the following cycle.

Source files
------------

// File: rtl/sample_buffer.sv
// Ready/valid first-word-fall-through sample FIFO with a DEPTH-entry circular buffer.
// Define SAMPLE_BUFFER_ERR_EN to add the sticky overflow/underflow flags (err_ovf, err_udf, err_clr).
module sample_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  A_data,
  input  logic              A_valid,
  output logic              A_ready,
  output logic [WIDTH-1:0]  Z_data,
  output logic              Z_valid,
  input  logic              Z_ready,
`ifdef SAMPLE_BUFFER_ERR_EN
  output logic              err_ovf,
  output logic              err_udf,
  input  logic              err_clr,
`endif
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_W:0]  wp_r;
  logic [ADDR_W:0]  rp_r;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;

  // The pointer MSB is a wrap bit, so equal indices mean full only when the laps differ.
  assign empty_s = (wp_r == rp_r);
  assign full_s  = (wp_r[ADDR_W-1:0] == rp_r[ADDR_W-1:0]) && (wp_r[ADDR_W] != rp_r[ADDR_W]);

  assign A_ready = !full_s && !reset;
  assign Z_valid = !empty_s;
  assign Z_data  = Z_valid ? mem_r[rp_r[ADDR_W-1:0]] : {WIDTH{1'b0}};
  assign count   = wp_r - rp_r;

  assign push_s  = A_valid && A_ready;
  assign pop_s   = Z_valid && Z_ready;

  // Pointer advance on accepted transfers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_r <= {(ADDR_W+1){1'b0}};
      rp_r <= {(ADDR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        wp_r <= wp_r + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
        wp_r <= wp_r;
      end
      if (pop_s) begin
        rp_r <= rp_r + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
        rp_r <= rp_r;
      end
    end
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wp_r[ADDR_W-1:0]] <= A_data;
    end
  end

`ifdef SAMPLE_BUFFER_ERR_EN
  logic err_ovf_r;
  logic err_udf_r;

  assign err_ovf = err_ovf_r;
  assign err_udf = err_udf_r;

  // Sticky protocol-violation flags; a new violation beats a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_ovf_r <= 1'b0;
      err_udf_r <= 1'b0;
    end else begin
      err_ovf_r <= (A_valid && full_s) || (err_ovf_r && !err_clr);
      err_udf_r <= (Z_ready && empty_s) || (err_udf_r && !err_clr);
    end
  end
`endif

endmodule
